// File: rtl/mmcm_lock_ctrl_if.sv
// mmcm_lock_ctrl_if: control/status bundle between the MMCM lock controller and its user.
// MMCM_LOCK_LOSS_CNT_EN adds the lock_loss_cnt_o status field.
interface mmcm_lock_ctrl_if #(
    parameter int MAX_RETRIES = 4
);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    logic          locked_i;
    logic          restart_i;
    logic          mmcm_rst_o;
    logic          ready_o;
    logic          fail_o;
    logic          lock_lost_o;
    logic [RW-1:0] retry_cnt_o;
    logic [2:0]    state_o;
`ifdef MMCM_LOCK_LOSS_CNT_EN
    logic [15:0]   lock_loss_cnt_o;
    modport master (output locked_i, restart_i,
                    input  mmcm_rst_o, ready_o, fail_o, lock_lost_o, retry_cnt_o, state_o, lock_loss_cnt_o);
    modport slave  (input  locked_i, restart_i,
                    output mmcm_rst_o, ready_o, fail_o, lock_lost_o, retry_cnt_o, state_o, lock_loss_cnt_o);
`else
    modport master (output locked_i, restart_i,
                    input  mmcm_rst_o, ready_o, fail_o, lock_lost_o, retry_cnt_o, state_o);
    modport slave  (input  locked_i, restart_i,
                    output mmcm_rst_o, ready_o, fail_o, lock_lost_o, retry_cnt_o, state_o);
`endif
endinterface

// File: rtl/mmcm_lock_ctrl.sv
// mmcm_lock_ctrl: MMCM reset pulse, lock wait with timeout/retries and lock stability qualification.
// Optional MMCM_LOCK_LOSS_CNT_EN adds a saturating 16-bit lock-loss counter.
module mmcm_lock_ctrl #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int STABLE_CYCLES       = 256,
    parameter int MAX_RETRIES         = 4,
    parameter int SYNC_STAGES         = 2
) (
    input  logic            ref_clk,
    input  logic            rst_n,
    mmcm_lock_ctrl_if.slave bus
);
    localparam int C01  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int CMAX = (C01 > STABLE_CYCLES) ? C01 : STABLE_CYCLES;
    localparam int CW   = $clog2(CMAX);
    localparam int RW   = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_WAIT  = 3'd1,
        S_STAB  = 3'd2,
        S_READY = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [RW-1:0]          r_retry;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_mmcm_rst;
    logic                   r_ready;
    logic                   r_fail;
    logic                   r_lost;
    logic                   w_locked_s;
    logic [RW-1:0]          w_retry_inc;
    logic                   w_exhaust;
    logic                   w_fail_attempt;
    logic                   w_loss_evt;

    assign w_locked_s     = r_sync[SYNC_STAGES-1];
    assign w_retry_inc    = r_retry + RW'(1);
    assign w_exhaust      = (w_retry_inc == RW'(MAX_RETRIES));
    // A timeout in WAIT and a lock drop in STAB are the same kind of failed attempt
    assign w_fail_attempt = !w_locked_s &&
                            ((r_state == S_WAIT && r_cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) || r_state == S_STAB);
    assign w_loss_evt     = (r_state == S_READY) && !w_locked_s && !bus.restart_i;

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.locked_i};
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RST;
            r_cnt      <= '0;
            r_retry    <= '0;
            r_mmcm_rst <= 1'b1;
            r_ready    <= 1'b0;
            r_fail     <= 1'b0;
            r_lost     <= 1'b0;
        end else begin
            r_lost <= 1'b0;
            r_cnt  <= r_cnt + CW'(1);
            if (bus.restart_i) begin
                r_state    <= S_RST;
                r_cnt      <= '0;
                r_retry    <= '0;
                r_fail     <= 1'b0;
                r_mmcm_rst <= 1'b1;
                r_ready    <= 1'b0;
            end else begin
                case (r_state)
                    S_RST: if (r_cnt == CW'(RST_PULSE_CYCLES - 1)) begin
                        r_state    <= S_WAIT;
                        r_cnt      <= '0;
                        r_mmcm_rst <= 1'b0;
                    end
                    S_WAIT, S_STAB: if (w_fail_attempt) begin
                        r_state    <= w_exhaust ? S_FAIL : S_RST;
                        r_cnt      <= '0;
                        r_retry    <= w_retry_inc;
                        r_fail     <= w_exhaust;
                        r_mmcm_rst <= 1'b1;
                    end else if (r_state == S_WAIT && w_locked_s) begin
                        r_state <= S_STAB;
                        r_cnt   <= '0;
                    end else if (r_state == S_STAB && r_cnt == CW'(STABLE_CYCLES - 1)) begin
                        r_state <= S_READY;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                    end
                    S_READY: begin
                        r_cnt <= '0;
                        if (w_loss_evt) begin
                            r_state    <= S_RST;
                            r_retry    <= '0;
                            r_ready    <= 1'b0;
                            r_mmcm_rst <= 1'b1;
                            r_lost     <= 1'b1;
                        end
                    end
                    S_FAIL: r_cnt <= '0;
                    default: begin
                        r_state    <= S_RST;
                        r_cnt      <= '0;
                        r_ready    <= 1'b0;
                        r_mmcm_rst <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.mmcm_rst_o  = r_mmcm_rst;
    assign bus.ready_o     = r_ready;
    assign bus.fail_o      = r_fail;
    assign bus.lock_lost_o = r_lost;
    assign bus.retry_cnt_o = r_retry;
    assign bus.state_o     = r_state;

`ifdef MMCM_LOCK_LOSS_CNT_EN
    logic [15:0] r_loss_cnt;
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n)                                  r_loss_cnt <= '0;
        else if (w_loss_evt && r_loss_cnt != 16'hFFFF) r_loss_cnt <= r_loss_cnt + 16'd1;
    end
    assign bus.lock_loss_cnt_o = r_loss_cnt;
`endif
endmodule

// File: tb/tb_mmcm_lock_ctrl.sv
// tb_mmcm_lock_ctrl: scenario tasks plus randomized run against a phase-level reference model.
module tb_mmcm_lock_ctrl;
    localparam int RP = 4, TO = 32, ST = 8, MR = 2, SS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mmcm_lock_ctrl_if #(.MAX_RETRIES(MR)) ifc();
    mmcm_lock_ctrl #(
        .RST_PULSE_CYCLES(RP), .LOCK_TIMEOUT_CYCLES(TO), .STABLE_CYCLES(ST),
        .MAX_RETRIES(MR), .SYNC_STAGES(SS)
    ) dut (.ref_clk(clk), .rst_n(rst_n), .bus(ifc));

    int vectors = 0;
    int miscompares = 0;

    // Phase model: ph 0 reset pulse, 1 waiting, 2 stabilising, 3 ready, 4 failed; t = cycles spent in phase
    typedef struct {
        int          ph;
        int          t;
        int          rc;
        bit          lost;
        bit [SS-1:0] h;
        int          lc;
    } mdl_t;
    mdl_t m;

    function automatic mdl_t nxt(mdl_t c, bit lk, bit rs);
        mdl_t n = c;
        bit   s = c.h[SS-1];
        n.h    = {c.h[SS-2:0], lk};
        n.lost = 1'b0;
        n.t    = c.t + 1;
        if (rs) begin
            n.ph = 0; n.t = 0; n.rc = 0;
        end else if (c.ph == 0 && c.t == RP - 1) begin
            n.ph = 1; n.t = 0;
        end else if (c.ph == 1 && s) begin
            n.ph = 2; n.t = 0;
        end else if ((c.ph == 1 && c.t == TO - 1) || (c.ph == 2 && !s)) begin
            n.rc = c.rc + 1; n.ph = (n.rc == MR) ? 4 : 0; n.t = 0;
        end else if (c.ph == 2 && c.t == ST - 1) begin
            n.ph = 3; n.t = 0;
        end else if (c.ph == 3 && !s) begin
            n.ph = 0; n.t = 0; n.rc = 0; n.lost = 1'b1;
            n.lc = (c.lc < 65535) ? c.lc + 1 : c.lc;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{ph: 0, t: 0, rc: 0, lost: 1'b0, h: '0, lc: 0};
        else        m <= nxt(m, ifc.locked_i, ifc.restart_i);
    end

    function automatic logic [8:0] dv();
        return {ifc.state_o, ifc.mmcm_rst_o, ifc.ready_o, ifc.fail_o, ifc.lock_lost_o, ifc.retry_cnt_o};
    endfunction
    function automatic logic [8:0] mv();
        return {3'(m.ph), m.ph == 0 || m.ph == 4, m.ph == 3, m.ph == 4, m.lost, 2'(m.rc)};
    endfunction

    task automatic do_reset();
        ifc.locked_i = 1'b0; ifc.restart_i = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, output int n);
        n = -1;
        for (int k = 0; k < lim; k++) begin
            if (ifc.state_o == s) begin n = k; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_ready(input int lim, output int n);
        n = -1;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (ifc.ready_o) begin n = k + 1; break; end
        end
    endtask

    task automatic pulse_width(output int w);
        w = 0;
        while (ifc.mmcm_rst_o && w < 100) begin w++; @(negedge clk); end
    endtask

    task automatic test_reset();
        ifc.locked_i = 1'b0; ifc.restart_i = 1'b0; rst_n = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if (dv() !== 9'b000_1_0_0_0_00) begin miscompares++; $display("FAIL reset_outputs: got %b exp %b", dv(), 9'b000_1_0_0_0_00); end
`ifdef MMCM_LOCK_LOSS_CNT_EN
        vectors++;
        if (ifc.lock_loss_cnt_o !== 16'd0) begin miscompares++; $display("FAIL reset_losscnt: got %0d exp 0", ifc.lock_loss_cnt_o); end
`endif
    endtask

    task automatic test_nominal();
        int w, n;
        do_reset();
        pulse_width(w);
        vectors++;
        if (w != RP) begin miscompares++; $display("FAIL nominal_pulse: got %0d exp %0d", w, RP); end
        repeat (10) @(negedge clk);
        ifc.locked_i = 1'b1;
        wait_ready(60, n);
        vectors++;
        if (n != SS + 1 + ST) begin miscompares++; $display("FAIL nominal_ready_latency: got %0d exp %0d", n, SS + 1 + ST); end
        vectors++;
        if (ifc.retry_cnt_o !== 2'd0 || ifc.fail_o !== 1'b0) begin miscompares++; $display("FAIL nominal_status: retry %0d fail %b exp 0 0", ifc.retry_cnt_o, ifc.fail_o); end
        vectors++;
        if (dv() !== mv()) begin miscompares++; $display("FAIL nominal_model: got %b exp %b", dv(), mv()); end
    endtask

    task automatic test_timeout();
        int w, n, k;
        do_reset();
        wait_state(3'd1, 20, n);
        k = 0;
        while (ifc.state_o == 3'd1 && k < 200) begin k++; @(negedge clk); end
        vectors++;
        if (k != TO) begin miscompares++; $display("FAIL timeout_wait_len: got %0d exp %0d", k, TO); end
        pulse_width(w);
        vectors++;
        if (w != RP) begin miscompares++; $display("FAIL timeout_second_pulse: got %0d exp %0d", w, RP); end
        repeat (5) @(negedge clk);
        ifc.locked_i = 1'b1;
        wait_ready(60, n);
        vectors++;
        if (n < 0 || ifc.retry_cnt_o !== 2'd1) begin miscompares++; $display("FAIL timeout_ready: wait %0d retry %0d exp ready retry 1", n, ifc.retry_cnt_o); end
        vectors++;
        if (dv() !== mv()) begin miscompares++; $display("FAIL timeout_model: got %b exp %b", dv(), mv()); end
    endtask

    task automatic test_exhaust();
        int w, n;
        do_reset();
        wait_state(3'd4, 300, n);
        vectors++;
        if (n < 0 || dv() !== 9'b100_1_0_1_0_10) begin miscompares++; $display("FAIL exhaust_fail_state: got %b exp %b", dv(), 9'b100_1_0_1_0_10); end
        repeat (6) @(negedge clk);
        vectors++;
        if (dv() !== mv() || ifc.mmcm_rst_o !== 1'b1) begin miscompares++; $display("FAIL exhaust_parked: got %b exp %b", dv(), mv()); end
        ifc.restart_i = 1'b1;
        @(negedge clk);
        ifc.restart_i = 1'b0;
        vectors++;
        if (ifc.fail_o !== 1'b0 || ifc.retry_cnt_o !== 2'd0 || ifc.state_o !== 3'd0) begin
            miscompares++; $display("FAIL exhaust_restart: fail %b retry %0d state %0d exp 0 0 0", ifc.fail_o, ifc.retry_cnt_o, ifc.state_o);
        end
        pulse_width(w);
        vectors++;
        if (w != RP) begin miscompares++; $display("FAIL exhaust_restart_pulse: got %0d exp %0d", w, RP); end
    endtask

    task automatic test_glitch();
        int w, n, k, rdy;
        do_reset();
        wait_state(3'd1, 20, n);
        ifc.locked_i = 1'b1;
        wait_state(3'd2, 20, n);
        repeat (4) @(negedge clk);
        ifc.locked_i = 1'b0;
        @(negedge clk);
        ifc.locked_i = 1'b1;
        k = 0; rdy = 0;
        while (ifc.state_o != 3'd0 && k < 20) begin rdy += int'(ifc.ready_o); k++; @(negedge clk); end
        vectors++;
        if (k >= 20 || rdy != 0) begin miscompares++; $display("FAIL glitch_abort: cycles %0d ready_seen %0d exp <20 0", k, rdy); end
        vectors++;
        if (ifc.retry_cnt_o !== 2'd1 || dv() !== mv()) begin miscompares++; $display("FAIL glitch_retry: got %b exp %b", dv(), mv()); end
        pulse_width(w);
        vectors++;
        if (w != RP) begin miscompares++; $display("FAIL glitch_pulse: got %0d exp %0d", w, RP); end
    endtask

    task automatic test_lock_loss();
        int w, n, k;
        do_reset();
        wait_state(3'd1, 20, n);
        ifc.locked_i = 1'b1;
        wait_ready(60, n);
        ifc.locked_i = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!ifc.lock_lost_o && k < 10);
        vectors++;
        if (k != SS + 1 || ifc.ready_o !== 1'b0 || ifc.mmcm_rst_o !== 1'b1) begin
            miscompares++; $display("FAIL loss_pulse: latency %0d ready %b rst %b exp %0d 0 1", k, ifc.ready_o, ifc.mmcm_rst_o, SS + 1);
        end
        pulse_width(w);
        vectors++;
        if (w != RP) begin miscompares++; $display("FAIL loss_reset_pulse: got %0d exp %0d", w, RP); end
        vectors++;
        if (ifc.lock_lost_o !== 1'b0) begin miscompares++; $display("FAIL loss_one_cycle: got %b exp 0", ifc.lock_lost_o); end
        ifc.locked_i = 1'b1;
        wait_ready(60, n);
        vectors++;
        if (n < 0 || dv() !== mv() || ifc.retry_cnt_o !== 2'd0) begin miscompares++; $display("FAIL loss_reacquire: got %b exp %b", dv(), mv()); end
`ifdef MMCM_LOCK_LOSS_CNT_EN
        vectors++;
        if (ifc.lock_loss_cnt_o !== 16'd1) begin miscompares++; $display("FAIL loss_count: got %0d exp 1", ifc.lock_loss_cnt_o); end
`endif
    endtask

    task automatic test_collision();
        int n;
        do_reset();
        wait_state(3'd1, 20, n);
        wait_state(3'd0, 60, n);
        wait_state(3'd1, 20, n);
        repeat (TO - 1) @(negedge clk);
        vectors++;
        if (ifc.state_o !== 3'd1 || ifc.retry_cnt_o !== 2'd1) begin miscompares++; $display("FAIL collide_setup: state %0d retry %0d exp 1 1", ifc.state_o, ifc.retry_cnt_o); end
        ifc.restart_i = 1'b1;
        @(negedge clk);
        ifc.restart_i = 1'b0;
        vectors++;
        if (dv() !== 9'b000_1_0_0_0_00) begin miscompares++; $display("FAIL collide_restart: got %b exp %b", dv(), 9'b000_1_0_0_0_00); end
        wait_state(3'd1, 20, n);
        ifc.locked_i = 1'b1;
        wait_state(3'd2, 20, n);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (dv() !== 9'b000_1_0_0_0_00) begin miscompares++; $display("FAIL collide_async_reset: got %b exp %b", dv(), 9'b000_1_0_0_0_00); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int hold = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            vectors++;
            if (dv() !== mv()) begin miscompares++; $display("FAIL random_cycle%0d: got %b exp %b", c, dv(), mv()); end
            if (ifc.ready_o && ifc.mmcm_rst_o) begin miscompares++; $display("FAIL random_exclusive: ready and mmcm_rst both 1 at cycle %0d", c); end
`ifdef MMCM_LOCK_LOSS_CNT_EN
            vectors++;
            if (int'(ifc.lock_loss_cnt_o) != m.lc) begin miscompares++; $display("FAIL random_losscnt: got %0d exp %0d", ifc.lock_loss_cnt_o, m.lc); end
`endif
            if (hold == 0) begin
                ifc.locked_i = ($urandom_range(0, 3) != 0);
                hold = $urandom_range(1, 60);
            end else hold--;
            ifc.restart_i = ($urandom_range(0, 199) == 0);
        end
        ifc.restart_i = 1'b0;
    endtask

    initial begin
        ifc.locked_i = 1'b0;
        ifc.restart_i = 1'b0;
        test_reset();
        test_nominal();
        test_timeout();
        test_exhaust();
        test_glitch();
        test_lock_loss();
        test_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
